// File: rtl/ifns_pkg.sv
// ifns_pkg: shared IFNS widths, weight/threshold tables and controller state type
package ifns_pkg;
    localparam int IFNS_VW = 22;
    localparam int IFNS_CW = 31;
    typedef enum logic [1:0] {IDLE, RUN, HOLD} ifns_state_e;
    // W[k] is the weight of digit k (W[31] is the top digit weight)
    localparam logic [IFNS_VW-1:0] IFNS_W [1:31] = '{
        22'd1, 22'd1, 22'd2, 22'd3, 22'd5, 22'd8, 22'd13, 22'd21, 22'd34, 22'd55,
        22'd89, 22'd144, 22'd233, 22'd377, 22'd610, 22'd987, 22'd1597, 22'd2584,
        22'd4181, 22'd6765, 22'd10946, 22'd17711, 22'd28657, 22'd46368, 22'd75025,
        22'd121393, 22'd196418, 22'd317811, 22'd514229, 22'd832040, 22'd2178309};
    // U[k] is the forcing threshold of digit k; U[k]=W[k+1] below the top two digits
    localparam logic [IFNS_VW-1:0] IFNS_U [1:31] = '{
        22'd1, 22'd2, 22'd3, 22'd5, 22'd8, 22'd13, 22'd21, 22'd34, 22'd55, 22'd89,
        22'd144, 22'd233, 22'd377, 22'd610, 22'd987, 22'd1597, 22'd2584, 22'd4181,
        22'd6765, 22'd10946, 22'd17711, 22'd28657, 22'd46368, 22'd75025, 22'd121393,
        22'd196418, 22'd317811, 22'd514229, 22'd832040, 22'd1346269, 22'd2178309};
endpackage

// File: rtl/ifns_digit_step.sv
// ifns_digit_step: resolves one IFNS digit and the remainder left after it
module ifns_digit_step
    import ifns_pkg::*;
(
    input  logic [IFNS_VW-1:0] r,
    input  logic               d_prev,
    input  logic [IFNS_VW-1:0] W,
    input  logic [IFNS_VW-1:0] U,
    input  logic               is_top,
    output logic               d,
    output logic [IFNS_VW-1:0] r_next
);
    // forced one at or above U, zero below W, otherwise repeat the previous digit
    always_comb begin
        d      = (r >= U) ? 1'b1 : (is_top || r < W) ? 1'b0 : d_prev;
        r_next = d ? r - W : r;
    end
endmodule

// File: rtl/ifns_enc_seq_ctrl.sv
// ifns_enc_seq_ctrl: sequential binary-to-IFNS encoder; IFNS_ENC_SEQ_2DPC_EN resolves two digits per cycle
module ifns_enc_seq_ctrl
    import ifns_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [IFNS_VW-1:0] in_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [IFNS_CW-1:0] out_code,
    output logic               busy
);
    ifns_state_e        r_state;
    ifns_state_e        w_state_nxt;
    logic [IFNS_VW-1:0] r_rem;
    logic [4:0]         r_cnt;
    logic [IFNS_CW-1:0] r_code;
    logic               r_dprev;
    logic [4:0]         w_k0;
    logic               w_d0;
    logic [IFNS_VW-1:0] w_r0;

    // digit index for the step; clamped so table lookups stay in range outside RUN
    always_comb begin
        w_k0 = (r_cnt < 5'd2) ? 5'd2 : r_cnt;
    end

    ifns_digit_step u_step0 (
        .r      (r_rem),
        .d_prev (r_dprev),
        .W      (IFNS_W[w_k0]),
        .U      (IFNS_U[w_k0]),
        .is_top (r_cnt == 5'd31),
        .d      (w_d0),
        .r_next (w_r0)
    );

`ifdef IFNS_ENC_SEQ_2DPC_EN
    logic [4:0]         w_k1;
    logic               w_d1;
    logic [IFNS_VW-1:0] w_r1;

    // second chained step resolves the digit just below the first
    always_comb begin
        w_k1 = w_k0 - 5'd1;
    end

    ifns_digit_step u_step1 (
        .r      (w_r0),
        .d_prev (w_d0),
        .W      (IFNS_W[w_k1]),
        .U      (IFNS_U[w_k1]),
        .is_top (1'b0),
        .d      (w_d1),
        .r_next (w_r1)
    );
`endif

    // state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_state_nxt;
    end

    // next-state: accept in IDLE, finish after digit 1, release on out_ready
    always_comb begin
        w_state_nxt = (r_state == IDLE) ? (in_valid ? RUN : IDLE) :
                      (r_state == RUN)  ? ((r_cnt == 5'd1) ? HOLD : RUN) :
                      (out_ready ? IDLE : HOLD);
    end

    // outputs decoded from state; codeword only visible while valid
    always_comb begin
        in_ready  = (r_state == IDLE);
        busy      = (r_state == RUN);
        out_valid = (r_state == HOLD);
        out_code  = out_valid ? r_code : '0;
    end

    // datapath: capture, then shift resolved digits into the code MSB first
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rem   <= '0;
            r_cnt   <= '0;
            r_code  <= '0;
            r_dprev <= 1'b0;
        end else if (r_state == IDLE && in_valid) begin
            r_rem   <= in_data;
            r_cnt   <= 5'd31;
            r_code  <= '0;
            r_dprev <= 1'b0;
        end else if (r_state == RUN) begin
            if (r_cnt == 5'd1) begin
                r_code <= {r_code[IFNS_CW-2:0], r_rem[0]};
                r_cnt  <= 5'd0;
            end else begin
`ifdef IFNS_ENC_SEQ_2DPC_EN
                r_code  <= {r_code[IFNS_CW-3:0], w_d0, w_d1};
                r_rem   <= w_r1;
                r_dprev <= w_d1;
                r_cnt   <= r_cnt - 5'd2;
`else
                r_code  <= {r_code[IFNS_CW-2:0], w_d0};
                r_rem   <= w_r0;
                r_dprev <= w_d0;
                r_cnt   <= r_cnt - 5'd1;
`endif
            end
        end
    end
endmodule

// File: tb/tb_ifns_enc_seq_ctrl.sv
// tb_ifns_enc_seq_ctrl: directed and random checks of the sequential IFNS encoder
module tb_ifns_enc_seq_ctrl;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [21:0] in_data = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [30:0] out_code;
    logic        busy;

    int n_cmp = 0;
    int n_bad = 0;
`ifdef IFNS_ENC_SEQ_2DPC_EN
    localparam int LAT = 17;
`else
    localparam int LAT = 32;
`endif
    int unsigned wt [1:31];
    int unsigned ut [1:31];

    ifns_enc_seq_ctrl dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_code  (out_code),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [30:0] ref_enc(input int unsigned v);
        int unsigned r = v;
        logic [30:0] c = '0;
        logic dp = 1'b0;
        logic d;
        for (int k = 31; k >= 2; k--) begin
            if (r >= ut[k]) d = 1'b1;
            else if (k == 31 || r < wt[k]) d = 1'b0;
            else d = dp;
            if (d) r = r - wt[k];
            c[k-1] = d;
            dp = d;
        end
        c[0] = r[0];
        return c;
    endfunction

    function automatic int unsigned code_sum(input logic [30:0] c);
        int unsigned s = 0;
        for (int k = 1; k <= 31; k++) if (c[k-1]) s += wt[k];
        return s;
    endfunction

    task automatic run_word(input logic [21:0] v, output logic [30:0] code, output int lat);
        in_data = v;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
        if (!out_valid) chk("timeout", 32'd0, 32'd1);
        code = out_code;
    endtask

    task automatic pop();
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    initial begin
        logic [30:0] code;
        logic [30:0] held;
        int lat;
        int seen;
        logic [21:0] dv [5] = '{22'd0, 22'd1, 22'd2, 22'd3, 22'd2178309};
        logic [30:0] dc [5] = '{31'h0, 31'h1, 31'h3, 31'h6, 31'h4000_0000};
        wt[1] = 1;
        wt[2] = 1;
        for (int k = 3; k <= 30; k++) wt[k] = wt[k-1] + wt[k-2];
        wt[31] = 2178309;
        for (int k = 1; k <= 29; k++) ut[k] = wt[k+1];
        ut[30] = 1346269;
        ut[31] = 2178309;

        #12;
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_out_code", {1'b0, out_code}, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 5; i++) begin
            run_word(dv[i], code, lat);
            chk($sformatf("code_%0d", dv[i]), {1'b0, code}, {1'b0, dc[i]});
            chk($sformatf("lat_%0d", dv[i]), lat, LAT);
            pop();
            chk("idle_after_pop", {31'd0, in_ready}, 32'd1);
        end

        run_word(22'd1000, code, lat);
        chk("code_1000", {1'b0, code}, {1'b0, ref_enc(1000)});
        held = code;
        in_data = 22'd77;
        in_valid = 1'b1;
        seen = 0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            if (out_code !== held || in_ready !== 1'b0 || out_valid !== 1'b1) seen++;
        end
        chk("hold_stable", seen, 0);
        in_valid = 1'b0;
        pop();
        seen = 0;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            if (busy !== 1'b0 || out_valid !== 1'b0) seen++;
        end
        chk("nothing_queued", seen, 0);

        in_data = 22'd12345;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (14) @(posedge clk);
        #1;
        chk("busy_in_run", {31'd0, busy}, 32'd1);
        rst_n = 1'b0;
        #2;
        chk("midrst_in_ready", {31'd0, in_ready}, 32'd1);
        chk("midrst_busy", {31'd0, busy}, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (out_valid) seen++;
        end
        chk("no_out_after_rst", seen, 0);
        run_word(22'd3, code, lat);
        chk("code_3_after_rst", {1'b0, code}, 32'h6);
        pop();

        for (int i = 0; i < 8; i++) begin
            logic [21:0] v;
            v = 22'($urandom);
            run_word(v, code, lat);
            chk($sformatf("rnd_code_%0d", v), {1'b0, code}, {1'b0, ref_enc(v)});
            chk($sformatf("rnd_sum_%0d", v), code_sum(code), {10'd0, v});
            pop();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/ifns_enc_seq_ctrl.md
IFNS_ENC_SEQ_CTRL -- requirements
Module: ifns_enc_seq_ctrl

Interface
REQ-001 SHALL have one clock and one reset: the clock is clk, and the reset is rst_n, asynchronous and active-low.
REQ-002 SHALL expose these ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous reset, active low.
- in_valid  in  1  input word offered.
- in_ready  out  1  controller can accept a word.
- in_data  in  22  binary value v to encode.
- out_valid  out  1  codeword available.
- out_ready  in  1  consumer accepts the codeword.
- out_code  out  31  IFNS codeword; out_code[30]=d31 ... out_code[0]=d1.
- busy  out  1  high while a conversion is in progress.

Function
REQ-003 SHALL sequence one shared digit-step datapath, resolving one IFNS digit per cycle from d31 down to d1.
REQ-004 SHALL use the FSM states IDLE, RUN and HOLD.
- IDLE: in_ready=1. On in_valid, capture in_data into the 22-bit remainder, load the digit counter with 31, clear the code register and go to RUN.
- RUN: each cycle, resolve digit[cnt], update the remainder, and decrement cnt. After digit 1 is resolved, go to HOLD.
- HOLD: out_valid=1. On out_ready, go to IDLE.
REQ-005 SHALL resolve digit 31 as: if r >= 2178309, then d=1 and r -= 2178309; otherwise d=0.
REQ-006 SHALL resolve each digit k from 30 down to 2 with weight W[k] and upper bound U[k]:
- if r >= U[k], then d=1;
- else if r < W[k], then d=0;
- else d = the previously resolved digit d[k+1].
- In all three cases, r -= d*W[k].
REQ-007 SHALL use U[30]=1346269 and U[k]=W[k+1] for k=2..29.
REQ-008 SHALL use the weights W[30..2] = 832040, 514229, 317811, 196418, 121393, 75025, 46368, 28657, 17711, 10946, 6765, 4181, 2584, 1597, 987, 610, 377, 233, 144, 89, 55, 34, 21, 13, 8, 5, 3, 2, 1.
REQ-009 SHALL resolve digit 1 as d1 = r[0].
REQ-010 SHALL perform all remainder arithmetic as unsigned 22-bit; no subtraction underflows, because d=1 implies r >= W[k].
REQ-011 SHALL have a latency of 32 cycles from the in_valid & in_ready handshake to out_valid high: 1 capture cycle plus 31 digit cycles.
REQ-012 SHALL hold out_code stable while out_valid=1 and out_ready=0.
REQ-013 SHALL keep in_ready at 0 in RUN and HOLD; in_valid asserted outside IDLE is ignored and nothing is queued.
REQ-014 SHALL drive busy=1 in RUN only.
REQ-015 SHALL hold out_code at 0 whenever out_valid=0.

Reset
REQ-016 SHALL, on rst_n low at any time (including mid-RUN or in HOLD), immediately enter IDLE, clear the remainder, counter, code register and previous-digit register to 0, and drive out_valid=0, busy=0, in_ready=1 once rst_n is high again.
REQ-017 SHALL discard any partially built codeword on reset; no output handshake occurs for it.

Configuration
REQ-018 SHALL, when IFNS_ENC_SEQ_2DPC_EN is defined, instantiate two chained digit steps and resolve two digits per cycle (31/30, 29/28, ..., 3/2, then d1 alone), giving a latency of 17 cycles.
REQ-019 SHALL, when IFNS_ENC_SEQ_2DPC_EN is undefined, use one digit step with a latency of 32 cycles.
REQ-020 SHALL produce bit-identical codewords with and without IFNS_ENC_SEQ_2DPC_EN.

Structure
REQ-021 SHALL take the following from shared package ifns_pkg:
- the W[] and U[] constant tables, indexed 1..31;
- the parameters IFNS_VW=22 and IFNS_CW=31;
- the state enum type.
REQ-022 SHALL place the per-digit decision and subtraction in combinational sub-module ifns_digit_step, with:
- inputs: r, d_prev, W, U, is_top;
- outputs: d, r_next.

Verification
REQ-023 The bench SHALL cover:
- in_data=0 -> out_code=31'h0000_0000 after 32 cycles.
- in_data=1 -> out_code=31'h0000_0001; in_data=2 -> 31'h0000_0003; in_data=3 -> 31'h0000_0006.
- in_data=2178309 -> out_code=31'h4000_0000.
- out_ready held low for 10 cycles in HOLD -> out_code is stable and in_ready=0 throughout; a new in_valid during that time is not accepted.
- rst_n pulsed low at cycle 15 of RUN -> out_valid never rises for that word; the next word, 3, yields 31'h0000_0006.
- Random 22-bit values with IFNS_ENC_SEQ_2DPC_EN on and off -> identical codewords, and sum(d_k*W[k]) with W[31]=2178309 equals in_data.
